// File: rtl/lcd_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_serial_pkg
// Purpose  : Shared types and constants for the serial LCD link: scheduler
//            state encoding, link constants and LCD command codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lcd_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } ser_state_t;

  localparam logic [7:0] SER_CMD_PREFIX       = 8'hFE;
  localparam logic [7:0] SER_BACKLIGHT_PREFIX = 8'h7C;
  localparam int         SER_BAUD_DIV_50M     = 5208;

  localparam logic [7:0] CLEAR           = 8'h01;
  localparam logic [7:0] SET_CURSOR_BASE = 8'h80;

  // Cursor address for a 16x2 panel: row 1 starts at DDRAM offset 0x40.
  function automatic logic [7:0] set_cursor(input logic row, input logic [3:0] col);
    return SET_CURSOR_BASE | {1'b0, row, 2'b00, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_uart_tx
// Purpose  : 8N1 serialiser. A load pulse starts a frame on the next cycle
//            (start bit, 8 data bits LSB first, stop bit), each bit held for
//            BAUD_DIV cycles. A load in the same cycle as done chains the next
//            frame with no idle cycle in between.
// Ports    : clk_50   - system clock
//            rst_n    - asynchronous active-low reset
//            load     - start a new frame with tx_byte
//            tx_byte  - byte to serialise
//            baud_cnt - position inside the current bit (0..BAUD_DIV-1)
//            bit_cnt  - current bit: 0 start, 1..8 data, 9 stop
//            done     - high on the last cycle of the stop bit
//            tx       - serial output, idles high
// Revision : 1.0 - initial release
// ============================================================================
module lcd_uart_tx #(
  parameter int BAUD_DIV = 4,
  parameter int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              load,
  input  logic [7:0]        tx_byte,
  output logic [BAUD_W-1:0] baud_cnt,
  output logic [3:0]        bit_cnt,
  output logic              done,
  output logic              tx
);

  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  logic              r_active;
  logic [8:0]        r_shift;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit;
  logic              r_tx;
  logic              w_bit_end;

  assign w_bit_end = r_active && (r_baud == c_BAUD_LAST);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_shift  <= '1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
    end else if (load) begin
      // Stop bit rides along as the top 1; shifting in 1s keeps it there.
      r_active <= 1'b1;
      r_shift  <= {1'b1, tx_byte};
      r_baud   <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          r_bit    <= '0;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  assign baud_cnt = r_baud;
  assign bit_cnt  = r_bit;
  assign done     = w_bit_end && (r_bit == 4'd9);
  assign tx       = r_tx;

endmodule
`default_nettype wire

// File: rtl/lcd_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lcd_serial_scheduler
// Purpose  : Shares the 9600-baud serial link to a 16x2 serial LCD between a
//            command source and a character source. Round-robin arbitration,
//            0xFE prefixing of commands, 8N1 framing and a settle gap after
//            every command pair.
// Ports    : clk_50    - system clock (only clock)
//            rst_n     - asynchronous active-low reset
//            cmd_valid - command byte available
//            cmd_byte  - command byte
//            cmd_ready - accept pulse for cmd_byte (only in IDLE)
//            dat_valid - character byte available
//            dat_byte  - ASCII character
//            dat_ready - accept pulse for dat_byte (only in IDLE)
//            tx        - serial line to the LCD, idles high
//            busy      - high from the cycle after a grant until IDLE
// Revision : 1.0 - initial release
// ============================================================================
module lcd_serial_scheduler
  import lcd_serial_pkg::*;
#(
  parameter int         BAUD_DIV      = SER_BAUD_DIV_50M,
  parameter logic [7:0] CMD_PREFIX    = SER_CMD_PREFIX,
  parameter int         CMD_GAP_BAUDS = 48
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       dat_valid,
  input  logic [7:0] dat_byte,
  output logic       dat_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int GAP_CYCLES = CMD_GAP_BAUDS * BAUD_DIV;
  localparam int GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [GAP_W-1:0]  c_GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ser_state_t        r_state;
  logic              r_pfx_pending;
  logic              r_cmd_pair;
  logic [7:0]        r_cmd_hold;
  logic              r_last_dat;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic              w_idle;
  logic              w_grant_cmd;
  logic              w_grant_dat;
  logic              w_chain;
  logic              w_load;
  logic [7:0]        w_load_byte;
  logic [BAUD_W-1:0] w_baud_cnt;
  logic [3:0]        w_bit_cnt;
  logic              w_done;
  logic              w_bit_end;

  // Readies are masked by rst_n so they stay low while reset is held even
  // though the state already reads IDLE.
  assign w_idle      = (r_state == IDLE) && rst_n;
  // r_last_dat=1 means data had the last grant, so a tie goes to cmd.
  assign w_grant_cmd = w_idle && cmd_valid && (!dat_valid || r_last_dat);
  assign w_grant_dat = w_idle && dat_valid && !w_grant_cmd;
  assign cmd_ready   = w_grant_cmd;
  assign dat_ready   = w_grant_dat;

  assign w_bit_end   = (w_baud_cnt == c_BAUD_LAST);
  assign w_chain     = (r_state == STOP) && w_done && r_pfx_pending;
  assign w_load      = w_grant_cmd || w_grant_dat || w_chain;
  assign w_load_byte = w_grant_cmd ? CMD_PREFIX :
                       w_grant_dat ? dat_byte   : r_cmd_hold;

  lcd_uart_tx #(
    .BAUD_DIV (BAUD_DIV),
    .BAUD_W   (BAUD_W)
  ) u_uart_tx (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .load     (w_load),
    .tx_byte  (w_load_byte),
    .baud_cnt (w_baud_cnt),
    .bit_cnt  (w_bit_cnt),
    .done     (w_done),
    .tx       (tx)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pfx_pending <= 1'b0;
      r_cmd_pair    <= 1'b0;
      r_cmd_hold    <= '0;
      r_last_dat    <= 1'b1;
      r_gap_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_cmd) begin
            r_state       <= START;
            r_pfx_pending <= 1'b1;
            r_cmd_pair    <= 1'b1;
            r_cmd_hold    <= cmd_byte;
            r_last_dat    <= 1'b0;
          end else if (w_grant_dat) begin
            r_state       <= START;
            r_pfx_pending <= 1'b0;
            r_cmd_pair    <= 1'b0;
            r_last_dat    <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) r_state <= DATA;
        end
        DATA: begin
          if (w_bit_end && (w_bit_cnt == 4'd8)) r_state <= STOP;
        end
        STOP: begin
          if (w_done) begin
            if (r_pfx_pending) begin
              // Serialiser is reloaded this cycle from r_cmd_hold.
              r_state       <= START;
              r_pfx_pending <= 1'b0;
            end else if (r_cmd_pair && (GAP_CYCLES > 0)) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == c_GAP_LAST) r_state   <= IDLE;
          else                         r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/lcd_serial_scheduler.md
Name: lcd_serial_scheduler

Overview:
Shares the single 9600-baud serial link to the SparkFun 16x2 serial LCD between two requesters: a command source and a character-data source. Arbitrates round-robin between them. Wraps each command byte with the 0xFE command prefix, serialises bytes as 8N1 frames, and enforces a settle gap after every command. Sits between the display-update logic and the LCD's RX pin. It replaces the free-running 9.6 kHz toggle clock with an internal baud counter.

Parameters:
BAUD_DIV, 5208, clk_50 cycles per serial bit (50 MHz / 9600); benches override it with 4.
CMD_PREFIX, 8'hFE, byte sent immediately before every command byte.
CMD_GAP_BAUDS, 48, idle bit-periods held after a command frame pair (about 5 ms at 9600 baud).

Ports:
clk_50  in  1  system clock, 50 MHz; the only clock.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command byte available.
cmd_byte  in  8  command byte (e.g. 8'h01 clear, 8'h80+addr set cursor).
cmd_ready  out  1  one-cycle pulse; cmd_byte is accepted when cmd_valid and cmd_ready are both 1.
dat_valid  in  1  character byte available.
dat_byte  in  8  ASCII character.
dat_ready  out  1  one-cycle pulse; dat_byte is accepted when dat_valid and dat_ready are both 1.
tx  out  1  serial line to the LCD; idles high.
busy  out  1  high from the cycle after a grant until the scheduler returns to IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, cmd_ready=0, dat_ready=0, busy=0.
  - state=IDLE; bit, baud and gap counters=0.
  - Round-robin pointer favours cmd.
  - A frame in progress is aborted with no truncated glitch beyond the forced-high tx.
- States:
  - IDLE, START, DATA, STOP, GAP.
  - Flag pfx_pending marks that the current byte is the prefix of a command pair.
- Arbitration (IDLE only):
  - Only one request pending: grant it.
  - Both pending: grant the side not granted last, then update the pointer.
  - At most one ready pulse per IDLE cycle; ready is never asserted outside IDLE.
- Handshake:
  - ready is combinationally qualified by valid. The byte is latched into shift_reg on the ready cycle.
  - The requester must hold the byte stable until ready; it may drop valid afterwards.
- Grant at cycle T:
  - Cycle T+1: state=START, tx=0, busy=1.
  - Command grant: shift_reg loads CMD_PREFIX, and the command byte is held in cmd_hold.
  - Data grant: shift_reg loads dat_byte.
- Bit timing:
  - Each bit lasts exactly BAUD_DIV cycles. The baud counter runs 0..BAUD_DIV-1 and advances the bit on terminal count.
  - START lasts one bit period.
  - DATA sends 8 bits, LSB first.
  - STOP drives tx=1 for one bit period.
- End of STOP:
  - pfx_pending=1: reload shift_reg from cmd_hold, clear pfx_pending, go to START. There is no idle cycle between the two frames.
  - Command byte complete: go to GAP. Hold tx=1 for CMD_GAP_BAUDS*BAUD_DIV cycles, then go to IDLE.
  - Data byte complete: go to IDLE.
- busy drops on the first IDLE cycle. The earliest next grant is that same cycle.
- Data frame: the grant at T is followed by the last stop cycle at T+10*BAUD_DIV and IDLE at T+10*BAUD_DIV+1.
- Counter widths: the baud counter is sized with $clog2(BAUD_DIV), and the gap counter with $clog2(CMD_GAP_BAUDS*BAUD_DIV+1). No wrap occurs within a frame.
- Requests arriving while busy are ignored (no ready) until IDLE; they are not queued.
- Simultaneous reset deassertion and valid: the first grant may occur on the first clk_50 edge after rst_n rises. cmd wins.

Decomposition:
- Package lcd_serial_pkg holds:
  - the state enum {IDLE, START, DATA, STOP, GAP};
  - constants SER_CMD_PREFIX=8'hFE, SER_BACKLIGHT_PREFIX=8'h7C, SER_BAUD_DIV_50M=5208;
  - LCD command codes CLEAR=8'h01 and SET_CURSOR_BASE=8'h80.
- Sub-module lcd_uart_tx contains the 8N1 serialiser:
  - ports: load, byte, baud counter, done pulse, tx;
  - the scheduler owns arbitration, prefixing and GAP.

Test Plan:
1. BAUD_DIV=4. rst_n low then high; dat_valid=1, dat_byte=8'h41 -> dat_ready pulses 1 cycle. tx bit sequence: 0,1,0,0,0,0,0,1,0,1, each held 4 cycles. busy=1 for 40 cycles.
2. BAUD_DIV=4, CMD_GAP_BAUDS=2. cmd_byte=8'h01 -> back-to-back frames 8'hFE then 8'h01 (80 cycles). tx then stays high 8 cycles before IDLE. busy=1 for 88 cycles.
3. cmd_valid and dat_valid both held high continuously -> grants alternate cmd, dat, cmd, dat, starting with cmd after reset. No second ready pulse for the same side before the other has been granted.
4. dat_valid asserted mid-frame -> no dat_ready until the first IDLE cycle; the grant then lands exactly 1 cycle after the stop bit ends.
5. rst_n pulled low during DATA bit 3 of a command prefix -> tx=1 and busy=0 immediately (asynchronous). After release, no residual 8'h01 frame is sent.
6. BAUD_DIV=5208 (default). Measure one data frame -> start bit width 5208 cycles; total frame 52080 cycles.
